// File: rtl/button_event_ctrl.sv
// rtl/button_event_ctrl.sv - per-button press/long/repeat/release events merged round-robin
// Define BTN_REPEAT_EN to emit REPEAT events while a button is held.
module button_event_ctrl #(
  parameter int N_BTN      = 4,
  parameter int ID_W       = 2,
  parameter int HOLD_CYC   = 50,
  parameter int REPEAT_CYC = 10,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_db,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [ID_W-1:0]  evt_id,
  output logic [1:0]       evt_type,
  output logic [N_BTN-1:0] pending,
  output logic [N_BTN-1:0] ovf
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PRESSED = 2'd1,
    S_HELD    = 2'd2
  } state_t;

  localparam logic [1:0] T_PRESS   = 2'b00;
  localparam logic [1:0] T_LONG    = 2'b01;
  localparam logic [1:0] T_RELEASE = 2'b11;
`ifdef BTN_REPEAT_EN
  localparam logic [1:0] T_REPEAT  = 2'b10;
  localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_CYC - 1);
`endif
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
  localparam int CNT_MAX = (HOLD_CYC > REPEAT_CYC) ? HOLD_CYC : REPEAT_CYC;
  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(CNT_MAX - 1);

  logic [N_BTN-1:0] r_btn_q;
  state_t           r_state     [N_BTN];
  state_t           w_state_nxt [N_BTN];
  logic [CNT_W-1:0] r_cnt       [N_BTN];
  logic [CNT_W-1:0] w_cnt_nxt   [N_BTN];
  logic [N_BTN-1:0] w_rise;
  logic [N_BTN-1:0] w_fall;
  logic [N_BTN-1:0] w_post;
  logic [1:0]       w_post_type [N_BTN];

  logic [N_BTN-1:0] r_pend;
  logic [1:0]       r_ptype [N_BTN];
  logic [N_BTN-1:0] r_ovf;
  logic [ID_W-1:0]  r_ptr;
  logic             r_valid;
  logic [ID_W-1:0]  r_id;
  logic [1:0]       r_type;

  logic             w_load;
  logic             w_gnt_vld;
  logic [ID_W-1:0]  w_gnt_idx;
  logic [N_BTN-1:0] w_gnt_oh;

  function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= N_BTN) s = s - N_BTN;
    return ID_W'(s);
  endfunction

  assign w_rise = btn_db & ~r_btn_q;
  assign w_fall = ~btn_db & r_btn_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_btn_q <= '0;
      for (int i = 0; i < N_BTN; i++) begin
        r_state[i] <= S_IDLE;
        r_cnt[i]   <= '0;
      end
    end else begin
      r_btn_q <= btn_db;
      for (int i = 0; i < N_BTN; i++) begin
        r_state[i] <= w_state_nxt[i];
        r_cnt[i]   <= w_cnt_nxt[i];
      end
    end
  end

  // A falling edge pre-empts any counter expiry in the same cycle.
  always_comb begin
    for (int i = 0; i < N_BTN; i++) begin
      w_state_nxt[i] = r_state[i];
      w_cnt_nxt[i]   = r_cnt[i];
      w_post[i]      = 1'b0;
      w_post_type[i] = T_PRESS;
      if (w_fall[i]) begin
        w_state_nxt[i] = S_IDLE;
        w_cnt_nxt[i]   = '0;
        w_post[i]      = 1'b1;
        w_post_type[i] = T_RELEASE;
      end else begin
        case (r_state[i])
          S_IDLE: begin
            if (w_rise[i]) begin
              w_state_nxt[i] = S_PRESSED;
              w_cnt_nxt[i]   = '0;
              w_post[i]      = 1'b1;
              w_post_type[i] = T_PRESS;
            end
          end
          S_PRESSED: begin
            if (r_cnt[i] == HOLD_LAST) begin
              w_state_nxt[i] = S_HELD;
              w_cnt_nxt[i]   = '0;
              w_post[i]      = 1'b1;
              w_post_type[i] = T_LONG;
            end else if (r_cnt[i] != CNT_TOP) begin
              w_cnt_nxt[i] = r_cnt[i] + 1'b1;
            end
          end
          S_HELD: begin
`ifdef BTN_REPEAT_EN
            if (r_cnt[i] == REP_LAST) begin
              w_cnt_nxt[i]   = '0;
              w_post[i]      = 1'b1;
              w_post_type[i] = T_REPEAT;
            end else begin
              w_cnt_nxt[i] = r_cnt[i] + 1'b1;
            end
`else
            w_cnt_nxt[i] = '0;
`endif
          end
          default: begin
            w_state_nxt[i] = S_IDLE;
            w_cnt_nxt[i]   = '0;
          end
        endcase
      end
    end
  end

  assign w_load = ~r_valid | evt_ready;

  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    for (int k = 0; k < N_BTN; k++) begin
      if (!w_gnt_vld && r_pend[wrap_idx(r_ptr, k)]) begin
        w_gnt_vld = 1'b1;
        w_gnt_idx = wrap_idx(r_ptr, k);
      end
    end
  end

  always_comb begin
    w_gnt_oh = '0;
    for (int i = 0; i < N_BTN; i++) begin
      w_gnt_oh[i] = w_load && w_gnt_vld && (w_gnt_idx == ID_W'(i));
    end
  end

  // A post landing on a slot that is not being drained this cycle loses the old event.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend <= '0;
      r_ovf  <= '0;
      for (int i = 0; i < N_BTN; i++) begin
        r_ptype[i] <= T_PRESS;
      end
    end else begin
      for (int i = 0; i < N_BTN; i++) begin
        if (w_post[i]) begin
          r_pend[i]  <= 1'b1;
          r_ptype[i] <= w_post_type[i];
          if (r_pend[i] && !w_gnt_oh[i]) r_ovf[i] <= 1'b1;
        end else if (w_gnt_oh[i]) begin
          r_pend[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_id    <= '0;
      r_type  <= T_PRESS;
      r_ptr   <= '0;
    end else if (w_load) begin
      r_valid <= w_gnt_vld;
      if (w_gnt_vld) begin
        r_id   <= w_gnt_idx;
        r_type <= r_ptype[w_gnt_idx];
        r_ptr  <= wrap_idx(w_gnt_idx, 1);
      end
    end
  end

  assign evt_valid = r_valid;
  assign evt_id    = r_id;
  assign evt_type  = r_type;
  assign pending   = r_pend;
  assign ovf       = r_ovf;

endmodule

// File: doc/button_event_ctrl.md
Name: button_event_ctrl

Overview:
- Sequences and shares the pushbutton inputs after per-button debouncing. Takes N debounced, active-high button levels and turns each one into press, long-press, auto-repeat and release events.
- A round-robin arbiter merges the per-button events into a single valid/ready event stream. Downstream UI/LCD control logic consumes that stream.
- Sits between the debounce instances and the top-level control FSM. All logic is on one clock domain.

Parameters:
- N_BTN, 4, number of button inputs (2..8).
- ID_W, 2, width of evt_id; must satisfy 2^ID_W >= N_BTN.
- HOLD_CYC, 50, cycles a button stays pressed before a LONG event (>=2).
- REPEAT_CYC, 10, cycles between REPEAT events while held (>=2).
- CNT_W, 8, hold/repeat counter width; must hold max(HOLD_CYC, REPEAT_CYC).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- btn_db  in  N_BTN  debounced button levels, 1 = pressed; synchronous to clk.
- evt_valid  out  1  event present on evt_id/evt_type.
- evt_ready  in  1  consumer accepts the event when evt_valid & evt_ready.
- evt_id  out  ID_W  index of the button that produced the event.
- evt_type  out  2  event type: 00 PRESS, 01 LONG, 10 REPEAT, 11 RELEASE.
- pending  out  N_BTN  per-button event-waiting flags.
- ovf  out  N_BTN  sticky per-button flag: an unserved event was overwritten.

Behaviour:
- Reset (async): evt_valid=0, evt_id=0, evt_type=0, pending=0, ovf=0. Internal state also clears: btn_q=0, all button FSMs IDLE, counters 0, round-robin pointer 0.
- Edge detect: btn_q is the registered copy of btn_db. rise[i] = btn_db[i] & ~btn_q[i]; fall[i] = ~btn_db[i] & btn_q[i].
- Per-button FSM, states IDLE / PRESSED / HELD:
  - IDLE: on rise -> PRESSED, cnt=0, post PRESS.
  - PRESSED: cnt increments each cycle. When cnt==HOLD_CYC-1 -> HELD, cnt=0, post LONG.
  - HELD: when cnt==REPEAT_CYC-1 -> cnt=0, post REPEAT (see REPEAT_EN).
  - Any state: fall -> IDLE, cnt=0, post RELEASE. Fall wins over a counter expiry in the same cycle.
- Pending slot, one per button (flag plus 2-bit type):
  - Posting sets pending[i] and stores the type.
  - If the slot is already set and not granted this cycle, the new event overwrites the old one and ovf[i] sets. ovf clears only on rst.
  - If the slot is granted and a new event is posted in the same cycle, the slot stays set with the new type, and ovf is not set.
- Output register:
  - Loads when evt_valid==0 or (evt_valid & evt_ready).
  - Arbiter searches pending starting at the pointer, wrapping modulo N_BTN. The first set bit is granted: evt_id/evt_type load, that pending bit clears, and pointer = grant+1 mod N_BTN.
  - If no bit is pending, evt_valid=0.
  - While evt_valid=1 and evt_ready=0, evt_id and evt_type hold stable.
- Latency: rise sampled at edge E0 -> pending at E0 -> evt_valid at E1 if the output is free. Sustained throughput is one event per cycle with evt_ready held at 1.
- Reset mid-hold: all state is lost. A button still held after reset produces a fresh PRESS, because btn_q resets to 0.

Optional Feature:
- Macro: BTN_REPEAT_EN.
- Defined: HELD posts a REPEAT every REPEAT_CYC cycles, as above.
- Undefined: HELD posts nothing until fall, and the REPEAT type is never generated. The repeat counter logic is removed.

Test Plan:
- Press/release: btn_db[2] goes 0->1 for 5 cycles, evt_ready=1 -> PRESS id=2 one cycle after the rise edge, then RELEASE id=2. No LONG.
- Long hold: btn_db[0] high for 75 cycles with HOLD_CYC=50, REPEAT_CYC=10 and BTN_REPEAT_EN defined -> PRESS, LONG 50 cycles later, REPEAT at +10 and +20, then RELEASE. With the macro undefined: PRESS, LONG, RELEASE only.
- Round-robin: buttons 0,1,3 rise in the same cycle, evt_ready=1 -> PRESS ids 0,1,3 on consecutive cycles. Next simultaneous PRESSes on buttons 0 and 1 start from pointer 0 (after 3), giving 0 then 1.
- Backpressure/overflow: evt_ready=0, button 1 pressed and released -> evt_valid stays 1 with id=1 PRESS stable. RELEASE replaces nothing already in the output register. A further PRESS on button 1 overwrites the pending RELEASE, and ovf[1]=1.
- Fall vs expiry: release button 0 exactly on the cycle cnt==HOLD_CYC-1 -> only RELEASE is posted, no LONG.
- Async reset: assert rst mid-HELD with evt_valid=1 -> all outputs 0 immediately. Deassert with the button still held -> fresh PRESS.
